// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the two pipeline requesters and the RAM arbiter.
// Port A is the instruction fetch (read only); port B is the memory stage (read/write).
interface ram_arbiter_if #(
    parameter int address_width = 8,
    parameter int data_width    = 8
);
    logic                     a_req;
    logic [address_width-1:0] a_addr;
    logic [data_width-1:0]    a_rdata;
    logic                     a_ack;

    logic                     b_req;
    logic                     b_we;
    logic [address_width-1:0] b_addr;
    logic [data_width-1:0]    b_wdata;
    logic [data_width-1:0]    b_rdata;
    logic                     b_ack;

    modport master (
        output a_req, a_addr,
        input  a_rdata, a_ack,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack
    );

    modport slave (
        input  a_req, a_addr,
        output a_rdata, a_ack,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for the fetch (A) and memory (B) stages.
// Every output, including the data_bus driver enable, comes straight from a flop.
// Build option RAM_ARB_FIXED_PRIO_EN: on simultaneous requests port B always wins;
// otherwise the port that did not win last time is granted (round-robin).
//
// state  | meaning
// IDLE   | strobes off, sample requests, grant and latch the winner's access
// ACCESS | RAM strobes held for ram_wait cycles, read data captured on the last edge
// DONE   | strobes off, one-cycle ack to the owner
module ram_arbiter #(
    parameter int address_width = 8,
    parameter int data_width    = 8,
    parameter int ram_wait      = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    ram_arbiter_if.slave             bus,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic                     ram_enable,
    output logic [address_width-1:0] address_bus,
    inout  wire  [data_width-1:0]    data_bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int               CW       = (ram_wait > 1) ? $clog2(ram_wait) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(ram_wait - 1);

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    owner_b, owner_b_d;
    logic                    we_q, we_d;
    logic                    last_b, last_b_d;
    logic                    drive_en, drive_en_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic [address_width-1:0] address_bus_d;
    logic                    wr_en_d, rd_en_d, ram_enable_d;
    logic                    a_ack_d, b_ack_d;
    logic [data_width-1:0]   a_rdata_d, b_rdata_d;
    logic                    grant_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign grant_b = bus.b_req;
`else
    assign grant_b = bus.b_req && (!bus.a_req || !last_b);
`endif

    assign data_bus = drive_en ? wdata_q : {data_width{1'bz}};

    // Next-state and next-output decode; strobes default to their idle levels.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        owner_b_d     = owner_b;
        we_d          = we_q;
        last_b_d      = last_b;
        wdata_d       = wdata_q;
        address_bus_d = address_bus;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        ram_enable_d  = 1'b1;
        drive_en_d    = 1'b0;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_rdata_d     = bus.a_rdata;
        b_rdata_d     = bus.b_rdata;
        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    owner_b_d     = grant_b;
                    we_d          = grant_b && bus.b_we;
                    wdata_d       = grant_b ? bus.b_wdata : wdata_q;
                    address_bus_d = grant_b ? bus.b_addr : bus.a_addr;
                    last_b_d      = grant_b;
                    cnt_d         = CNT_LOAD;
                    state_d       = ACCESS;
                    ram_enable_d  = 1'b0;
                    rd_en_d       = !we_d;
                    wr_en_d       = we_d;
                    drive_en_d    = we_d;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_d = DONE;
                    a_ack_d = !owner_b;
                    b_ack_d = owner_b;
                    if (!we_q) begin
                        if (owner_b) b_rdata_d = data_bus;
                        else         a_rdata_d = data_bus;
                    end
                end else begin
                    cnt_d        = cnt - 1'b1;
                    ram_enable_d = 1'b0;
                    rd_en_d      = !we_q;
                    wr_en_d      = we_q;
                    drive_en_d   = we_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered outputs; reset abandons any access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_b     <= 1'b0;
            we_q        <= 1'b0;
            last_b      <= 1'b1;
            wdata_q     <= '0;
            drive_en    <= 1'b0;
            address_bus <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            ram_enable  <= 1'b1;
            bus.a_ack   <= 1'b0;
            bus.b_ack   <= 1'b0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            owner_b     <= owner_b_d;
            we_q        <= we_d;
            last_b      <= last_b_d;
            wdata_q     <= wdata_d;
            drive_en    <= drive_en_d;
            address_bus <= address_bus_d;
            wr_en       <= wr_en_d;
            rd_en       <= rd_en_d;
            ram_enable  <= ram_enable_d;
            bus.a_ack   <= a_ack_d;
            bus.b_ack   <= b_ack_d;
            bus.a_rdata <= a_rdata_d;
            bus.b_rdata <= b_rdata_d;
        end
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM between two requesters of the 8-bit 5-stage core: port A (instruction fetch, read-only) and port B (memory stage, read/write).
- Sequences the RAM control strobes (wr_en, rd_en, active-low ram_enable), the address bus and the bidirectional data bus.
- Returns read data to the granted requester with a one-cycle ack.
- Sits between the pipeline stages and the RAM.

Parameters:
address_width, 8, RAM address width
data_width, 8, RAM data width
ram_wait, 1, cycles the RAM strobes are held per access (>=1)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
a_req  input  1  fetch read request, level, held until a_ack
a_addr  input  address_width  fetch address, stable while a_req
a_rdata  output  data_width  fetch read data
a_ack  output  1  one-cycle completion pulse for port A
b_req  input  1  memory-stage request, level, held until b_ack
b_we  input  1  1=write, 0=read; stable while b_req
b_addr  input  address_width  memory-stage address
b_wdata  input  data_width  memory-stage write data
b_rdata  output  data_width  memory-stage read data
b_ack  output  1  one-cycle completion pulse for port B
wr_en  output  1  RAM write strobe, active high
rd_en  output  1  RAM read strobe, active high
ram_enable  output  1  RAM chip enable, active low
address_bus  output  address_width  RAM address
data_bus  inout  data_width  RAM data; driven only during write access, else high-Z

Behaviour:
- All outputs registered; data_bus driver enable registered.
- Reset values: wr_en=0, rd_en=0, ram_enable=1, address_bus=0, data_bus=Z, a_ack=b_ack=0, a_rdata=b_rdata=0, state=IDLE, wait counter=0, last_grant=B.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples a_req/b_req. If neither is set, stays in IDLE with strobes deasserted.
  - If one is set, grants it. If both are set, grants the port not in last_grant (round-robin).
  - On grant: latches owner, addr, we (A is always read) and wdata; updates last_grant; loads the counter with ram_wait-1; goes to ACCESS.
- ACCESS:
  - Holds ram_enable=0, address_bus=latched addr, and rd_en=~we, wr_en=we, for exactly ram_wait cycles.
  - On a write, drives data_bus=latched wdata during these cycles only.
  - The counter decrements each cycle.
  - On the clock edge ending the last ACCESS cycle of a read, captures data_bus into the owner's rdata.
  - Then goes to DONE.
- DONE:
  - Strobes deasserted: wr_en=rd_en=0, ram_enable=1, data_bus=Z.
  - The owner's ack is high for this one cycle. rdata is valid in this cycle and held until the next read completes on that port.
  - Goes to IDLE.
- Latency: a request sampled at edge N produces ACCESS cycles N+1..N+ram_wait, ack in cycle N+ram_wait+1, and IDLE at N+ram_wait+2. Peak throughput is one access per ram_wait+2 cycles.
- Handshake:
  - The requester drops req in its ack cycle.
  - req still high in the following IDLE cycle is a new request.
  - The non-granted port keeps req high and waits, with no timeout.
  - Inputs changing while a request is pending are ignored after the IDLE latch.
- A write never updates b_rdata.
- Ack on the non-owner port is never asserted.
- Reset asserted in any state: at the next edge all outputs return to reset values, any in-flight access is abandoned, no ack is issued, and data_bus is released.
- No cycle has wr_en and rd_en both high.
- No cycle has data_bus driven while rd_en=1.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: when both requests are pending in IDLE, port B always wins (memory stage over fetch). last_grant is not used.
- Undefined: round-robin as described above.

Test Plan:
- Reset then a_req only, a_addr=8'h05, RAM[5]=8'h5A, ram_wait=1 -> rd_en/ram_enable=0 for 1 cycle, a_ack 2 cycles after sampling, a_rdata=8'h5A, b_ack never high.
- b_req, b_we=1, b_addr=8'h0F, b_wdata=8'hC3, then b read of 8'h0F -> data_bus=8'hC3 only during the write ACCESS cycle, later b_rdata=8'hC3.
- a_req and b_req held together for 4 grants after reset -> grant order A,B,A,B. With RAM_ARB_FIXED_PRIO_EN: B,B,B,B while b_req is held.
- ram_wait=3, write 8'h10->addr 8'h02 -> wr_en high exactly 3 cycles, b_ack in 4th cycle after sampling, never wr_en&rd_en.
- Reset pulsed during ACCESS of a read -> next cycle wr_en=rd_en=0, ram_enable=1, data_bus=Z, no ack, rdata=0.
- a_req held high through its ack -> second read of the same address starts in the following IDLE, producing back-to-back acks spaced ram_wait+2 cycles apart.
